io_port_bridge: RTL and testbench

- Peripheral-side I/O stage directly downstream of the pipelined CPU's port interface.
- Consumes the CPU's execute-stage `port_id`, `out_port` and `io_strb`, and produces the `in_port` byte that the CPU captures into its writeback register.
- Latches an LED register and buffers outbound bytes in a small TX FIFO with a valid/ready drain.
- Synchronizes and edge-detects pushbuttons into maskable pending bits that drive the CPU's `input_interrupt`.

---
 rtl/io_port_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_io_port_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// io_port_bridge: peripheral-side I/O stage for the pipelined CPU port bus.
// Decodes port writes into an LED register, a TX byte FIFO with a
// valid/ready drain and button interrupt control. Returns read data
// combinationally from port_id. Pushbuttons are synchronized and
// rising-edge detected into maskable pending bits that drive a
// registered interrupt.
module io_port_bridge #(
    parameter int FIFO_DEPTH = 8,
    parameter int BTN_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           port_id,
    input  logic [7:0]           out_port,
    input  logic                 io_strb,
    output logic [7:0]           in_port,
    input  logic [7:0]           switches,
    input  logic [BTN_WIDTH-1:0] buttons,
    output logic [7:0]           leds,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 interrupt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Port map
    localparam logic [7:0] ID_RD_SWITCHES = 8'h20;
    localparam logic [7:0] ID_RD_BUTTONS  = 8'h21;
    localparam logic [7:0] ID_RD_STATUS   = 8'h22;
    localparam logic [7:0] ID_RD_PENDING  = 8'h23;
    localparam logic [7:0] ID_RD_MASK     = 8'h24;
    localparam logic [7:0] ID_WR_LEDS     = 8'h40;
    localparam logic [7:0] ID_WR_TX       = 8'h41;
    localparam logic [7:0] ID_WR_W1C      = 8'h42;
    localparam logic [7:0] ID_WR_MASK     = 8'h43;
    localparam logic [7:0] ID_WR_OVF_CLR  = 8'h44;

    // ------------------------------------------------------------------
    // Write strobes
    // ------------------------------------------------------------------
    logic wr_leds;
    logic wr_tx;
    logic wr_w1c;
    logic wr_mask;
    logic wr_ovf_clr;

    assign wr_leds    = io_strb && (port_id == ID_WR_LEDS);
    assign wr_tx      = io_strb && (port_id == ID_WR_TX);
    assign wr_w1c     = io_strb && (port_id == ID_WR_W1C);
    assign wr_mask    = io_strb && (port_id == ID_WR_MASK);
    assign wr_ovf_clr = io_strb && (port_id == ID_WR_OVF_CLR);

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    logic [7:0] leds_reg;

    // Latch the LED byte on an OUT to the LED port
    always_ff @(posedge clk) begin
        if (rst) begin
            leds_reg <= 8'h00;
        end else if (wr_leds) begin
            leds_reg <= out_port;
        end
    end

    assign leds = leds_reg;

    // ------------------------------------------------------------------
    // TX FIFO: pointers carry one extra wrap bit so full and empty can be
    // told apart without a separate count.
    // ------------------------------------------------------------------
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push_ok;
    logic        pop_ok;
    logic        overflow_reg;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A push into a full FIFO is dropped even if a pop frees a slot this
    // same cycle; the fullness seen by the CPU at the strobe decides.
    assign push_ok = wr_tx && !fifo_full;
    assign pop_ok  = !fifo_empty && tx_ready;

    // Store accepted bytes; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= out_port;
        end
    end

    // Advance the write and read pointers; reset discards everything queued
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Sticky overflow flag, set by a dropped push and cleared by its own port
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (wr_tx && fifo_full) begin
            overflow_reg <= 1'b1;
        end else if (wr_ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg[AW-1:0]];

    // ------------------------------------------------------------------
    // Buttons: 2-flop synchronizer, rising-edge detect, pending/mask
    // ------------------------------------------------------------------
    logic [BTN_WIDTH-1:0] btn_meta_reg;
    logic [BTN_WIDTH-1:0] btn_sync_reg;
    logic [BTN_WIDTH-1:0] btn_prev_reg;
    logic [BTN_WIDTH-1:0] btn_rise;
    logic [BTN_WIDTH-1:0] pending_reg;
    logic [BTN_WIDTH-1:0] pending_next;
    logic [BTN_WIDTH-1:0] mask_reg;
    logic                 interrupt_reg;

    // Bring the asynchronous buttons into the clock domain and keep the
    // previous synchronized sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_reg <= '0;
            btn_sync_reg <= '0;
            btn_prev_reg <= '0;
        end else begin
            btn_meta_reg <= buttons;
            btn_sync_reg <= btn_meta_reg;
            btn_prev_reg <= btn_sync_reg;
        end
    end

    // Per-bit pending update: a fresh rising edge beats a coincident W1C
    for (genvar gi = 0; gi < BTN_WIDTH; gi++) begin : g_btn
        assign btn_rise[gi]     = btn_sync_reg[gi] && !btn_prev_reg[gi];
        assign pending_next[gi] = btn_rise[gi] ||
                                  (pending_reg[gi] && !(wr_w1c && out_port[gi]));
    end

    // Pending bits collect edges regardless of the mask
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // Interrupt enable mask
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= '0;
        end else if (wr_mask) begin
            mask_reg <= out_port[BTN_WIDTH-1:0];
        end
    end

    // Registered level interrupt from the enabled pending bits
    always_ff @(posedge clk) begin
        if (rst) begin
            interrupt_reg <= 1'b0;
        end else begin
            interrupt_reg <= |(pending_reg & mask_reg);
        end
    end

    assign interrupt = interrupt_reg;

    // ------------------------------------------------------------------
    // Read decode
    // ------------------------------------------------------------------
    logic [7:0] btn_ext;
    logic [7:0] pending_ext;
    logic [7:0] mask_ext;
    logic [7:0] status_byte;

    // Zero-extend the narrow button-side fields to a full port byte
    always_comb begin
        btn_ext                       = 8'h00;
        pending_ext                   = 8'h00;
        mask_ext                      = 8'h00;
        btn_ext[BTN_WIDTH-1:0]        = btn_sync_reg;
        pending_ext[BTN_WIDTH-1:0]    = pending_reg;
        mask_ext[BTN_WIDTH-1:0]       = mask_reg;
    end

    assign status_byte = {5'b00000, overflow_reg, fifo_full, fifo_empty};

    // Side-effect-free read mux addressed directly by port_id
    always_comb begin
        in_port = 8'h00;
        case (port_id)
            ID_RD_SWITCHES: in_port = switches;
            ID_RD_BUTTONS:  in_port = btn_ext;
            ID_RD_STATUS:   in_port = status_byte;
            ID_RD_PENDING:  in_port = pending_ext;
            ID_RD_MASK:     in_port = mask_ext;
            default:        in_port = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed testbench for io_port_bridge: LED writes, TX FIFO fill/overflow/
// drain, simultaneous push+pop, button interrupt latency, W1C vs. edge race
// and mid-operation reset.
module tb_io_port_bridge;

    logic       clk;
    logic       rst;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;
    logic [7:0] in_port;
    logic [7:0] switches;
    logic [3:0] buttons;
    logic [7:0] leds;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       interrupt;

    int checks;
    int failures;

    io_port_bridge #(
        .FIFO_DEPTH(8),
        .BTN_WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .port_id  (port_id),
        .out_port (out_port),
        .io_strb  (io_strb),
        .in_port  (in_port),
        .switches (switches),
        .buttons  (buttons),
        .leds     (leds),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .interrupt(interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs and samples sit 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
        $display("check %-14s observed=%02h expected=%02h", tag, observed, expected);
    endtask

    // Combinational read: drive port_id and let in_port settle
    task automatic rd_check(input string tag, input logic [7:0] id,
                            input logic [7:0] expected);
        port_id = id;
        #1;
        check(tag, in_port, expected);
    endtask

    // One OUT instruction: strobe for exactly one clock edge
    task automatic wr(input logic [7:0] id, input logic [7:0] data);
        port_id  = id;
        out_port = data;
        io_strb  = 1'b1;
        tick();
        io_strb  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        port_id  = 8'h00;
        out_port = 8'h00;
        io_strb  = 1'b0;
        switches = 8'h5C;
        buttons  = 4'b0000;
        tx_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // 1. reset state
        rd_check("rst_status", 8'h22, 8'h01);
        rd_check("rst_pending", 8'h23, 8'h00);
        check("rst_leds", leds, 8'h00);
        check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_irq", {7'b0, interrupt}, 8'h00);
        rd_check("rd_switches", 8'h20, 8'h5C);
        rd_check("rd_unmapped", 8'h99, 8'h00);

        // 2. LED register
        wr(8'h40, 8'hA5);
        check("leds_write", leds, 8'hA5);
        port_id  = 8'h40;
        out_port = 8'h3C;
        io_strb  = 1'b0;
        tick();
        check("leds_nostrb", leds, 8'hA5);

        // 3. fill, overflow, drain in order
        for (int i = 0; i < 8; i++) wr(8'h41, 8'h11 + 8'(i));
        rd_check("fifo_full", 8'h22, 8'h02);
        wr(8'h41, 8'h99);
        rd_check("fifo_ovf", 8'h22, 8'h06);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", {7'b0, tx_valid}, 8'h01);
            check("drain_data", tx_data, 8'h11 + 8'(i));
            tick();
        end
        tx_ready = 1'b0;
        check("drained_valid", {7'b0, tx_valid}, 8'h00);
        check("drained_data", tx_data, 8'h00);
        rd_check("drained_status", 8'h22, 8'h05);
        wr(8'h44, 8'h00);
        rd_check("ovf_clear", 8'h22, 8'h01);

        // 4. simultaneous push and pop with 3 bytes held
        wr(8'h41, 8'hA1);
        wr(8'h41, 8'hA2);
        wr(8'h41, 8'hA3);
        check("three_head", tx_data, 8'hA1);
        tx_ready = 1'b1;
        wr(8'h41, 8'h77);
        tx_ready = 1'b0;
        check("pp_head", tx_data, 8'hA2);
        tx_ready = 1'b1;
        check("pp_out1", tx_data, 8'hA2);
        tick();
        check("pp_out2", tx_data, 8'hA3);
        tick();
        check("pp_out3", tx_data, 8'h77);
        tick();
        tx_ready = 1'b0;
        check("pp_empty", {7'b0, tx_valid}, 8'h00);

        // 5. button interrupt latency
        wr(8'h43, 8'h01);
        rd_check("mask_read", 8'h24, 8'h01);
        buttons = 4'b0001;
        tick();                                   // edge N
        tick();                                   // edge N+1
        rd_check("pend_n1", 8'h23, 8'h00);
        rd_check("btn_sync", 8'h21, 8'h01);
        tick();                                   // edge N+2
        rd_check("pend_n2", 8'h23, 8'h01);
        check("irq_n2", {7'b0, interrupt}, 8'h00);
        tick();                                   // edge N+3
        check("irq_n3", {7'b0, interrupt}, 8'h01);
        buttons = 4'b0011;
        tick();
        tick();
        tick();
        rd_check("pend_b1", 8'h23, 8'h03);
        check("irq_b1", {7'b0, interrupt}, 8'h01);
        wr(8'h42, 8'h01);
        rd_check("pend_w1c", 8'h23, 8'h02);
        check("irq_w1c_1", {7'b0, interrupt}, 8'h01);
        tick();
        check("irq_w1c_2", {7'b0, interrupt}, 8'h00);

        // 6. falling edge ignored, then W1C racing a new edge
        buttons = 4'b0010;
        tick();
        tick();
        tick();
        rd_check("pend_fall", 8'h23, 8'h02);
        buttons = 4'b0011;
        tick();
        tick();
        tick();
        tick();
        rd_check("pend_re", 8'h23, 8'h03);
        check("irq_re", {7'b0, interrupt}, 8'h01);
        buttons = 4'b0010;
        tick();
        tick();
        tick();
        buttons = 4'b0011;
        tick();                                   // edge N
        tick();                                   // edge N+1
        wr(8'h42, 8'h01);                         // edge N+2: rise and W1C coincide
        rd_check("race_pend", 8'h23, 8'h03);
        tick();
        check("race_irq", {7'b0, interrupt}, 8'h01);
        rd_check("race_pend2", 8'h23, 8'h03);

        // reset mid-operation with FIFO content and LEDs set
        wr(8'h41, 8'h55);
        wr(8'h41, 8'h66);
        buttons = 4'b0000;
        tx_ready = 1'b1;
        rst = 1'b1;
        tick();
        check("mrst_leds", leds, 8'h00);
        check("mrst_valid", {7'b0, tx_valid}, 8'h00);
        check("mrst_data", tx_data, 8'h00);
        check("mrst_irq", {7'b0, interrupt}, 8'h00);
        rd_check("mrst_status", 8'h22, 8'h01);
        rd_check("mrst_pending", 8'h23, 8'h00);
        rd_check("mrst_mask", 8'h24, 8'h00);
        rd_check("mrst_btn", 8'h21, 8'h00);
        rst = 1'b0;
        tx_ready = 1'b0;
        wr(8'h41, 8'h9E);
        check("post_valid", {7'b0, tx_valid}, 8'h01);
        check("post_data", tx_data, 8'h9E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
